// File: rtl/serial_add_sub_4bit_pkg.sv
// Shared types and defaults for the bit-serial 4-bit adder/subtractor.
package serial_add_sub_4bit_pkg;

    // Default operand width.
    localparam int unsigned Width = 4;

    // Controller states: waiting for a start request, or stepping through bits.
    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } state_e;

endpackage

// File: rtl/FullAdder.sv
// Single-bit full adder cell used as the serial datapath.
module FullAdder (
    input  logic i_A,
    input  logic i_B,
    input  logic i_Cin,
    output logic o_sum,
    output logic o_carry
);

    // Plain one-bit sum and majority carry.
    always_comb begin
        o_sum   = i_A ^ i_B ^ i_Cin;
        o_carry = (i_A & i_B) | (i_A & i_Cin) | (i_B & i_Cin);
    end

endmodule

// File: rtl/serial_add_sub_4bit.sv
// Bit-serial adder/subtractor: one full-adder step per clock, LSB first.
// Subtraction is A + ~B + 1, with the +1 injected through the initial carry.
module serial_add_sub_4bit
    import serial_add_sub_4bit_pkg::*;
#(
    parameter int unsigned WIDTH = Width
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_sub,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             cy_q, cy_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] b_mux;
    logic             fa_sum;
    logic             fa_carry;

    // B-inversion mux feeding the operand capture.
    assign b_mux = i_sub ? ~i_B : i_B;

    FullAdder u_fa (
        .i_A    (a_q[0]),
        .i_B    (b_q[0]),
        .i_Cin  (cy_q),
        .o_sum  (fa_sum),
        .o_carry(fa_carry)
    );

    // All storage; reset clears everything and aborts any operation in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cy_q    <= 1'b0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cy_q    <= cy_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    // Next-state: capture on start in idle, one adder step per edge in run.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cy_d    = cy_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    a_d     = i_A;
                    b_d     = b_mux;
                    cy_d    = i_sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cy_d  = fa_carry;
                cnt_d = cnt_q + CntW'(1);
                res_d = {fa_sum, res_q[WIDTH-1:1]};
                // Published results only change on the final step, so they hold
                // steady for the whole of the following operation.
                if (cnt_q == LastCnt) begin
                    sum_d   = {fa_sum, res_q[WIDTH-1:1]};
                    carry_d = fa_carry;
                    ovf_d   = cy_q ^ fa_carry;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs straight from flops; busy is a decode of the state register.
    assign o_sum      = sum_q;
    assign o_carry    = carry_q;
    assign o_overflow = ovf_q;
    assign o_done     = done_q;
    assign o_busy     = (state_q == StRun);

endmodule
